// File: rtl/scoreboard_hazard_unit.sv
// Register scoreboard for an in-order pipeline. It tracks the remaining producer latency for each
// register, detects RAW/WAW hazards in ID, and generates stall, flush and issue.

module scoreboard_cnt_entry #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt
);
  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = load_val;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

module scoreboard_hazard_unit #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int MAX_LAT      = 3,
  parameter int LAT_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs1_addr,
  input  logic                id_rs1_used,
  input  logic [ADDR_W-1:0]   id_rs2_addr,
  input  logic                id_rs2_used,
  input  logic [ADDR_W-1:0]   id_rd_addr,
  input  logic                id_rd_we,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                ex_redirect,
  output logic                stall,
  output logic                flush,
  output logic                issue,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic [15:0]         stall_count
);
  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [LAT_W-1:0] lat_eff;
  logic             raw1, raw2, waw, raw_stall, rd_nz;
  logic [2:0]       fl_cnt_q, fl_cnt_d;
  logic [15:0]      stall_count_q, stall_count_d;

  // The clamp only exists when the latency field can encode values above MAX_LAT.
  if (MAX_LAT < (2**LAT_W) - 1) begin : g_clamp
    assign lat_eff = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
  end else begin : g_noclamp
    assign lat_eff = id_lat;
  end

  assign rd_nz     = (id_rd_addr != '0);
  assign raw1      = id_valid && id_rs1_used && (id_rs1_addr != '0) && (cnt[id_rs1_addr] != '0);
  assign raw2      = id_valid && id_rs2_used && (id_rs2_addr != '0) && (cnt[id_rs2_addr] != '0);
  assign waw       = id_valid && id_rd_we && rd_nz && (cnt[id_rd_addr] > lat_eff);
  assign raw_stall = raw1 || raw2 || waw;

  assign flush = ex_redirect || (fl_cnt_q != '0);
  assign stall = raw_stall && !flush;
  assign issue = id_valid && !stall && !flush;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_ent
      logic ld;
      assign ld = issue && id_rd_we && (id_rd_addr == ADDR_W'(r));
      scoreboard_cnt_entry #(.LAT_W(LAT_W)) u_ent (
        .clk(clk), .rst_n(rst_n), .load(ld), .load_val(lat_eff), .cnt(cnt[r])
      );
    end
    assign sb_busy[r] = (cnt[r] != '0);
  end

  // A redirect, including one inside a live window, restarts the tail of the flush window.
  always_comb begin
    fl_cnt_d = fl_cnt_q;
    if (ex_redirect)            fl_cnt_d = 3'(FLUSH_CYCLES - 1);
    else if (fl_cnt_q != '0)    fl_cnt_d = fl_cnt_q - 3'd1;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fl_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      fl_cnt_q      <= fl_cnt_d;
      stall_count_q <= stall_count_d;
    end

  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit: a vector table for the main program,
// plus hand-written reset-mid-stall, clamp and saturation sequences.

module tb_scoreboard_hazard_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, ex_redirect;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [1:0] id_lat;
  logic stall, flush, issue;
  logic [31:0] sb_busy;
  logic [15:0] stall_count;

  scoreboard_hazard_unit #(.NUM_REGS(32), .ADDR_W(5), .MAX_LAT(3), .LAT_W(2), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .id_lat(id_lat), .ex_redirect(ex_redirect), .stall(stall), .flush(flush), .issue(issue),
    .sb_busy(sb_busy), .stall_count(stall_count)
  );

  // Wider-latency instance: exercises the clamp and reaches counter saturation in ~70k cycles.
  logic b_valid, b_rs1_used, b_rd_we, b_redirect;
  logic [4:0] b_rs1, b_rd;
  logic [3:0] b_lat;
  logic b_stall, b_flush, b_issue;
  logic [31:0] b_busy;
  logic [15:0] b_scnt;

  scoreboard_hazard_unit #(.NUM_REGS(32), .ADDR_W(5), .MAX_LAT(14), .LAT_W(4), .FLUSH_CYCLES(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(b_valid), .id_rs1_addr(b_rs1), .id_rs1_used(b_rs1_used),
    .id_rs2_addr(5'd0), .id_rs2_used(1'b0), .id_rd_addr(b_rd), .id_rd_we(b_rd_we),
    .id_lat(b_lat), .ex_redirect(b_redirect), .stall(b_stall), .flush(b_flush), .issue(b_issue),
    .sb_busy(b_busy), .stall_count(b_scnt)
  );

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we; logic [1:0] lat; logic redir;
    logic e_stall; logic e_flush; logic e_issue; int bidx; logic e_busy; int e_scnt;
  } vec_t;

  vec_t tv[25];
  int checks = 0, failures = 0;

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic we, logic [1:0] lat, logic redir,
                              logic st, logic fl, logic is, int bidx, logic busy, int scnt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.we = we; t.lat = lat;
    t.redir = redir; t.e_stall = st; t.e_flush = fl; t.e_issue = is; t.bidx = bidx;
    t.e_busy = busy; t.e_scnt = scnt;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1_addr = t.rs1; id_rs1_used = t.u1; id_rs2_addr = t.rs2; id_rs2_used = t.u2;
    id_rd_addr = t.rd; id_rd_we = t.we; id_lat = t.lat; ex_redirect = t.redir;
  endtask

  initial begin
    id_valid = 0; id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
    id_rd_addr = 0; id_rd_we = 0; id_lat = 0; ex_redirect = 1;
    b_valid = 0; b_rs1 = 0; b_rs1_used = 0; b_rd = 0; b_rd_we = 0; b_lat = 0; b_redirect = 0;

    //       v rs1 u1 rs2 u2 rd we lat rd | st fl is bidx busy scnt
    tv[0]  = mk(1, 0, 0, 0, 0,  5, 1, 1, 0,  0, 0, 1,  5, 0, 0); // load x5
    tv[1]  = mk(1, 5, 1, 1, 1,  6, 1, 0, 0,  1, 0, 0,  5, 1, 0); // add x6,x5,x1
    tv[2]  = mk(1, 5, 1, 1, 1,  6, 1, 0, 0,  0, 0, 1,  5, 0, 1);
    tv[3]  = mk(1, 0, 0, 0, 0,  7, 1, 3, 0,  0, 0, 1,  7, 0, 1); // div x7
    tv[4]  = mk(1, 7, 1, 0, 0,  8, 1, 0, 0,  1, 0, 0,  7, 1, 1);
    tv[5]  = mk(1, 7, 1, 0, 0,  8, 1, 0, 0,  1, 0, 0,  7, 1, 2);
    tv[6]  = mk(1, 7, 1, 0, 0,  8, 1, 0, 0,  1, 0, 0,  7, 1, 3);
    tv[7]  = mk(1, 7, 1, 0, 0,  8, 1, 0, 0,  0, 0, 1,  7, 0, 4);
    tv[8]  = mk(1, 0, 0, 0, 0,  7, 1, 3, 0,  0, 0, 1,  7, 0, 4); // div x7
    tv[9]  = mk(1, 1, 1, 0, 0,  7, 1, 0, 0,  1, 0, 0,  7, 1, 4); // ALU x7: WAW
    tv[10] = mk(1, 1, 1, 0, 0,  7, 1, 0, 0,  1, 0, 0,  7, 1, 5);
    tv[11] = mk(1, 1, 1, 0, 0,  7, 1, 0, 0,  1, 0, 0,  7, 1, 6);
    tv[12] = mk(1, 1, 1, 0, 0,  7, 1, 0, 0,  0, 0, 1,  7, 0, 7);
    tv[13] = mk(1, 7, 1, 0, 0,  8, 1, 0, 0,  0, 0, 1,  7, 0, 7);
    tv[14] = mk(1, 0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 1,  0, 0, 7); // load x0
    tv[15] = mk(1, 0, 1, 0, 1,  8, 1, 0, 0,  0, 0, 1,  0, 0, 7);
    tv[16] = mk(1, 0, 0, 0, 0,  9, 1, 3, 0,  0, 0, 1,  9, 0, 7); // div x9
    tv[17] = mk(1, 9, 1, 0, 0, 10, 1, 0, 0,  1, 0, 0,  9, 1, 7);
    tv[18] = mk(1, 9, 1, 0, 0, 10, 1, 0, 1,  0, 1, 0,  9, 1, 8); // redirect wins over RAW
    tv[19] = mk(1, 9, 1, 0, 0, 10, 1, 0, 1,  0, 1, 0,  9, 1, 8); // second redirect
    tv[20] = mk(1, 9, 1, 0, 0, 10, 1, 0, 0,  0, 1, 0,  9, 0, 8);
    tv[21] = mk(1, 9, 1, 0, 0, 10, 1, 0, 0,  0, 0, 1,  9, 0, 8);
    tv[22] = mk(1, 0, 0, 0, 0, 10, 1, 2, 0,  0, 0, 1, 10, 0, 8); // load x10 lat 2
    tv[23] = mk(1,10, 0,10, 0, 11, 1, 0, 0,  0, 0, 1, 10, 1, 8); // sources unused
    tv[24] = mk(0,10, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 10, 1, 8); // no valid instruction

    // Reset state
    #12;
    chk("rst_stall", 0, 32'(stall), 32'd0);
    chk("rst_busy", 0, sb_busy, 32'd0);
    chk("rst_scnt", 0, 32'(stall_count), 32'd0);
    chk("rst_flush_redir", 0, 32'(flush), 32'd1);
    ex_redirect = 0; #1;
    chk("rst_flush_noredir", 0, 32'(flush), 32'd0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk("stall", i, 32'(stall), 32'(tv[i].e_stall));
      chk("flush", i, 32'(flush), 32'(tv[i].e_flush));
      chk("issue", i, 32'(issue), 32'(tv[i].e_issue));
      chk("busy", i, 32'(sb_busy[tv[i].bidx]), 32'(tv[i].e_busy));
      chk("busy0", i, 32'(sb_busy[0]), 32'd0);
      chk("scnt", i, 32'(stall_count), 32'(tv[i].e_scnt));
    end

    // Reset mid-stall with cnt[5]=2
    @(negedge clk); drive(mk(1, 0, 0, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mid_stall", 0, 32'(stall), 32'd1);
    chk("mid_busy5", 0, 32'(sb_busy[5]), 32'd1);
    rst_n = 0; ex_redirect = 1; #1;
    chk("mid_rst_stall", 0, 32'(stall), 32'd0);
    chk("mid_rst_busy", 0, sb_busy, 32'd0);
    chk("mid_rst_scnt", 0, 32'(stall_count), 32'd0);
    chk("mid_rst_flush", 0, 32'(flush), 32'd1);
    ex_redirect = 0; #1;
    chk("mid_rst_flush0", 0, 32'(flush), 32'd0);
    @(negedge clk); rst_n = 1; #1;
    chk("post_rst_stall", 0, 32'(stall), 32'd0);
    chk("post_rst_issue", 0, 32'(issue), 32'd1);
    @(negedge clk); id_valid = 0; #1;
    chk("post_rst_scnt", 0, 32'(stall_count), 32'd0);
    chk("post_rst_busy6", 0, 32'(sb_busy[6]), 32'd0);

    // Latency 15 clamps to 14: each group is one issue plus 14 stall cycles.
    for (int g = 0; g < 4682; g++) begin
      @(negedge clk);
      b_valid = 1; b_rs1 = 0; b_rs1_used = 0; b_rd = 5'd3; b_rd_we = 1; b_lat = 4'd15;
      @(negedge clk);
      b_rs1 = 5'd3; b_rs1_used = 1; b_rd_we = 0; b_lat = 4'd0;
      if (g == 0) begin
        #1 chk("sat_first_stall", 0, 32'(b_stall), 32'd1);
      end
      repeat (13) @(negedge clk);
      if (g == 0) begin
        #1 chk("clamp_scnt13", 0, 32'(b_scnt), 32'd13);
        chk("clamp_last_stall", 0, 32'(b_stall), 32'd1);
        @(negedge clk); #1;
        chk("clamp_release", 0, 32'(b_stall), 32'd0);
        chk("clamp_scnt14", 0, 32'(b_scnt), 32'd14);
        chk("clamp_busy3", 0, 32'(b_busy[3]), 32'd0);
        // Offset the next group start by the extra negedge already taken.
        b_valid = 1; b_rs1_used = 0; b_rd_we = 1; b_lat = 4'd15;
        @(posedge clk);
        @(negedge clk);
        b_rs1 = 5'd3; b_rs1_used = 1; b_rd_we = 0; b_lat = 4'd0;
        repeat (13) @(negedge clk);
      end
    end
    @(negedge clk); #1;
    chk("sat_scnt", 0, 32'(b_scnt), 32'hFFFF);
    b_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
